// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC rotation engine.
// All angle and magnitude constants are Q2.30 two's complement.
package cordic_pkg;

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the per-iteration shift amount (covers shifts 0..31).
  localparam int SHIFT_W   = 5;
  localparam int MAX_ITERS = 32;
  localparam int ATAN_W    = 32;

  // Reciprocal CORDIC gain; callers prescale their input magnitude by it.
  localparam logic [31:0] CORDIC_K = 32'h26DD3B6A;

  // round(atan(2^-i) * 2^30). Past i=10 the entries collapse to 2^(30-i),
  // and the last entry rounds to zero.
  localparam logic [31:0] ATAN_TABLE [0:MAX_ITERS-1] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
    32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
    32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
    32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
    32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
    32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
    32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
    32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
  };

  // Arctangent lookup for a given micro-rotation index.
  function automatic logic [31:0] atan_lookup(input logic [SHIFT_W-1:0] idx);
    return ATAN_TABLE[idx];
  endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// One CORDIC micro-rotation: a purely combinational shift-accumulate step
// with a variable arithmetic shift. The rotation direction follows the sign
// of the residual angle; z == 0 rotates in the negative direction.
module cordic_iter_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   z,
  input  logic [WIDTH-1:0]   atan,
  input  logic [SHIFT_W-1:0] shift,
  output logic [WIDTH-1:0]   x_next,
  output logic [WIDTH-1:0]   y_next,
  output logic [WIDTH-1:0]   z_next
);

  logic [WIDTH-1:0] x_shr;
  logic [WIDTH-1:0] y_shr;
  logic             z_pos;

  // Arithmetic shifts and the strictly-positive test on the residual angle.
  always_comb begin
    x_shr = $signed(x) >>> shift;
    y_shr = $signed(y) >>> shift;
    z_pos = $signed(z) > $signed({WIDTH{1'b0}});
  end

  // Rotate towards zero residual angle; sums wrap modulo 2^WIDTH.
  always_comb begin
    x_next = x;
    y_next = y;
    z_next = z;
    if (z_pos) begin
      x_next = x - y_shr;
      y_next = y + x_shr;
      z_next = z - atan;
    end else begin
      x_next = x + y_shr;
      y_next = y - x_shr;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation engine. A single micro-rotation stage is reused
// for ITERS cycles; this controller owns the x/y/z registers, the iteration
// counter that also serves as shift amount and arctangent index, and the
// valid/ready handshakes on the operand and result sides.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int ITERS  = 16,
  localparam int ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x_in,
  input  logic [WIDTH-1:0]  y_in,
  input  logic [WIDTH-1:0]  z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  x_out,
  output logic [WIDTH-1:0]  y_out,
  output logic [WIDTH-1:0]  z_out,
  output logic              busy,
  output logic [ITER_W-1:0] iter
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

  state_t              state_r;
  logic [ITER_W-1:0]   iter_r;
  logic [WIDTH-1:0]    x_r;
  logic [WIDTH-1:0]    y_r;
  logic [WIDTH-1:0]    z_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;

  logic [SHIFT_W-1:0]  shift_s;
  logic [ATAN_W-1:0]   atan32_s;
  logic [WIDTH-1:0]    atan_s;
  logic [WIDTH-1:0]    x_next_s;
  logic [WIDTH-1:0]    y_next_s;
  logic [WIDTH-1:0]    z_next_s;

  // The iteration index doubles as shift amount and table index.
  assign shift_s  = SHIFT_W'(iter_r);
  assign atan32_s = atan_lookup(shift_s);

  // Align the Q2.30 table to the datapath width (keep the binary point
  // two bits below the MSB).
  generate
    if (WIDTH == ATAN_W) begin : g_atan_same
      assign atan_s = atan32_s;
    end else if (WIDTH > ATAN_W) begin : g_atan_wide
      assign atan_s = {atan32_s, {(WIDTH - ATAN_W){1'b0}}};
    end else begin : g_atan_narrow
      assign atan_s = atan32_s[ATAN_W-1 -: WIDTH];
    end
  endgenerate

  cordic_iter_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .atan   (atan_s),
    .shift  (shift_s),
    .x_next (x_next_s),
    .y_next (y_next_s),
    .z_next (z_next_s)
  );

  // Control FSM, iteration counter, datapath registers and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      iter_r      <= {ITER_W{1'b0}};
      x_r         <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      z_r         <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            x_r        <= x_in;
            y_r        <= y_in;
            z_r        <= z_in;
            iter_r     <= {ITER_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          x_r <= x_next_s;
          y_r <= y_next_s;
          z_r <= z_next_s;
          if (iter_r == LAST_ITER) begin
            iter_r      <= {ITER_W{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            iter_r <= iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          iter_r      <= {ITER_W{1'b0}};
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers.
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign iter      = iter_r;
  assign x_out     = x_r;
  assign y_out     = y_r;
  assign z_out     = z_r;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl: a driver pushes the reference
// model's answer for each accepted operand, a monitor acting as the result
// consumer pops and compares on every result handshake.
module tb_cordic_iter_ctrl;

  localparam int WIDTH = 32;
  localparam int ITERS = 16;
  localparam int ITER_W = 4;
  localparam int K_Q30 = 32'h26DD3B6A;

  typedef struct {
    int x;
    int y;
    int z;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x_in, y_in, z_in;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  x_out, y_out, z_out;
  logic              busy;
  logic [ITER_W-1:0] iter;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;          // consumer: 0 always ready, 1 random, 2 hold 10 cycles
  int   atan_ref [0:31];
  res_t exp_q [$];
  int   acc_q [$];
  int   last_x, last_y, last_z;
  int   done_cnt = 0;

  cordic_iter_ctrl #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy),
    .iter      (iter)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_eq(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void check_near(string nm, int act, int exp, int tol);
    longint d;
    d = longint'(act) - longint'(exp);
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s got %h expected %h +/- %0d", nm, act, exp, tol);
    end
  endfunction

  // Plain CORDIC rotation with 32-bit wrapping integers.
  function automatic res_t ref_model(int xi, int yi, int zi);
    res_t r;
    int nx, ny;
    r.x = xi; r.y = yi; r.z = zi;
    for (int i = 0; i < ITERS; i++) begin
      if (r.z > 0) begin
        nx = r.x - (r.y >>> i); ny = r.y + (r.x >>> i); r.z = r.z - atan_ref[i];
      end else begin
        nx = r.x + (r.y >>> i); ny = r.y - (r.x >>> i); r.z = r.z + atan_ref[i];
      end
      r.x = nx; r.y = ny;
    end
    return r;
  endfunction

  // Offer an operand (called at a negedge); returns the accepting edge index.
  task automatic issue(input int xi, input int yi, input int zi, output int acc);
    int n;
    x_in = xi; y_in = yi; z_in = zi; in_valid = 1'b1; acc = -1;
    for (n = 0; n < 400; n++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1 within 400 cycles");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_model(xi, yi, zi));
      acc = cyc + 1;
      acc_q.push_back(acc);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    for (n = 0; n < bound; n++) begin
      if (exp_q.size() == 0 && !busy && !out_valid) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d expected 0", exp_q.size());
    end
  endtask

  // Monitor / consumer: decides out_ready, checks latency, stability, results.
  initial begin : monitor
    bit   prev_ov;
    bit   held;
    int   hold_cnt;
    int   hx, hy, hz;
    res_t e;
    prev_ov = 1'b0; held = 1'b0; hold_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0; held = 1'b0; hold_cnt = 0;
      end else begin
        if (held) begin
          check_eq("hold_stable", {out_valid, in_ready, x_out, y_out, z_out},
                   {1'b1, 1'b0, hx[31:0], hy[31:0], hz[31:0]});
        end
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stray_out_valid got 1 expected 0 at cycle %0d", cyc);
          end else begin
            check_eq("latency", cyc - acc_q.pop_front(), ITERS);
          end
        end
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = 1'($urandom_range(0, 1));
          default: begin
            if (out_valid && hold_cnt < 10) begin
              out_ready = 1'b0; hold_cnt++;
            end else begin
              out_ready = 1'b1;
            end
          end
        endcase
        held = out_valid && !out_ready;
        hx = x_out; hy = y_out; hz = z_out;
        if (out_valid && out_ready) begin
          hold_cnt = 0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result got x=%h expected no result", x_out);
          end else begin
            e = exp_q.pop_front();
            check_eq("result_x", x_out, e.x[31:0]);
            check_eq("result_y", y_out, e.y[31:0]);
            check_eq("result_z", z_out, e.z[31:0]);
          end
          last_x = x_out; last_y = y_out; last_z = z_out;
          done_cnt++;
        end
        prev_ov = out_valid;
      end
    end
  end

  // Stimulus sequence.
  initial begin : driver
    int a0, a1, a2, a3;
    int rz, rx, ry;
    bit stray;
    for (int i = 0; i < 32; i++)
      atan_ref[i] = $rtoi($atan($pow(2.0, -1.0 * i)) * 1073741824.0 + 0.5);
    in_valid = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_state", {in_ready, out_valid, busy, iter, x_out, y_out, z_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_after_reset", in_ready, 1);

    // +45 degrees
    mode = 0;
    issue(K_Q30, 0, 32'h3243F6A9, a0); in_valid = 1'b0;
    wait_idle(100);
    check_near("pos45_x", last_x, 32'h2D413CCD, 65536);
    check_near("pos45_y", last_y, 32'h2D413CCD, 65536);
    check_near("pos45_z", last_z, 0, 65535);

    // -45 degrees
    issue(K_Q30, 0, 32'hCDBC0957, a0); in_valid = 1'b0;
    wait_idle(100);
    check_near("neg45_x", last_x, 32'h2D413CCD, 65536);
    check_near("neg45_y", last_y, 32'hD2BEC333, 65536);

    // Zero angle: first micro-rotation takes the negative direction
    issue(K_Q30, 0, 0, a0); in_valid = 1'b0;
    @(negedge clk);
    check_eq("zero_first_z", z_out, 32'h3243F6A9);
    check_eq("zero_first_iter", iter, 1);
    wait_idle(100);
    check_near("zero_x", last_x, 32'h40000000, 65536);
    check_near("zero_y", last_y, 0, 65536);

    // Back-to-back spacing with the consumer always ready
    issue(K_Q30, 0, 32'h10000000, a1);
    issue(K_Q30, 0, 32'hF0000000, a2);
    issue(K_Q30, 0, 32'h20000000, a3);
    in_valid = 1'b0;
    check_eq("spacing_1", a2 - a1, ITERS + 2);
    check_eq("spacing_2", a3 - a2, ITERS + 2);
    wait_idle(100);

    // Backpressure with stray in_valid pulses during RUN and DONE
    mode = 2;
    issue(K_Q30, 0, 32'h18000000, a1); in_valid = 1'b0;
    @(negedge clk);
    x_in = 32'h11111111; y_in = 32'h22222222; z_in = 32'h33333333; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    check_eq("bp_reached_done", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    issue(K_Q30, 32'h01000000, 32'hE8000000, a2); in_valid = 1'b0;
    check_eq("bp_second_after_release", (a2 - a1) >= (ITERS + 12), 1);
    wait_idle(200);

    // Reset in the middle of RUN (cycle 5 of 16)
    mode = 0;
    issue(K_Q30, 0, 32'h20000000, a0); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete(); acc_q.delete();
    check_eq("midrun_reset", {out_valid, busy, iter, x_out, y_out, z_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_after_midrun_reset", in_ready, 1);
    stray = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    check_eq("no_stray_after_reset", stray, 0);

    // Random angles with a random consumer
    mode = 1;
    for (int k = 0; k < 100; k++) begin
      rz = int'($urandom_range(0, 32'd3221225472)) - 32'sd1610612736;
      rx = int'($urandom_range(0, 32'h3FFFFFFF)) - 32'sh20000000;
      ry = int'($urandom_range(0, 32'h3FFFFFFF)) - 32'sh20000000;
      issue(rx, ry, rz, a0);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    wait_idle(300);
    check_eq("result_count", done_cnt, 108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
